// File: rtl/s444_mon_pkg.sv
// Shared definitions for the two-approach lamp monitor: phase codes, lamp
// encodings, error codes and the transition table.
package s444_mon_pkg;

    typedef enum logic [2:0] {
        PH_UNLOCKED = 3'd0,
        PH_AG       = 3'd1,
        PH_AY       = 3'd2,
        PH_RED_A    = 3'd3,
        PH_BG       = 3'd4,
        PH_BY       = 3'd5,
        PH_RED_B    = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ENCODING   = 2'd1,
        ERR_TRANSITION = 2'd2,
        ERR_SHORT      = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ENC_ILLEGAL,
        ENC_AG,
        ENC_AY,
        ENC_ALLRED,
        ENC_BG,
        ENC_BY
    } enc_t;

    // Lamp vector order is {A_R, A_Y, A_G, B_R, B_Y, B_G}
    localparam logic [5:0] LAMP_AG     = 6'b001100;
    localparam logic [5:0] LAMP_AY     = 6'b010100;
    localparam logic [5:0] LAMP_ALLRED = 6'b100100;
    localparam logic [5:0] LAMP_BG     = 6'b100001;
    localparam logic [5:0] LAMP_BY     = 6'b100010;

    localparam logic [7:0] DWELL_MAX = 8'hFF;

    function automatic enc_t decode_lamp(input logic [5:0] lamp);
        enc_t enc;
        case (lamp)
            LAMP_AG:     enc = ENC_AG;
            LAMP_AY:     enc = ENC_AY;
            LAMP_ALLRED: enc = ENC_ALLRED;
            LAMP_BG:     enc = ENC_BG;
            LAMP_BY:     enc = ENC_BY;
            default:     enc = ENC_ILLEGAL;
        endcase
        return enc;
    endfunction

    function automatic enc_t phase_enc(input phase_t phase);
        enc_t enc;
        case (phase)
            PH_AG:              enc = ENC_AG;
            PH_AY:              enc = ENC_AY;
            PH_RED_A, PH_RED_B: enc = ENC_ALLRED;
            PH_BG:              enc = ENC_BG;
            PH_BY:              enc = ENC_BY;
            default:            enc = ENC_ILLEGAL;
        endcase
        return enc;
    endfunction

    // All-red resolves to RED_A or RED_B depending on which yellow preceded it;
    // PH_UNLOCKED is returned for any transition outside the legal ring.
    function automatic phase_t successor(input phase_t phase, input enc_t enc);
        phase_t next;
        next = PH_UNLOCKED;
        case (phase)
            PH_AG:    if (enc == ENC_AY)     next = PH_AY;
            PH_AY:    if (enc == ENC_ALLRED) next = PH_RED_A;
            PH_RED_A: if (enc == ENC_BG)     next = PH_BG;
            PH_BG:    if (enc == ENC_BY)     next = PH_BY;
            PH_BY:    if (enc == ENC_ALLRED) next = PH_RED_B;
            PH_RED_B: if (enc == ENC_AG)     next = PH_AG;
            default:  next = PH_UNLOCKED;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/s444_dwell_ctr.sv
// 8-bit dwell counter: clear to 0, load 1 on phase entry, saturating increment.
module s444_dwell_ctr
    import s444_mon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic       load,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (en) begin
            if (clear) begin
                count <= 8'd0;
            end else if (load) begin
                count <= 8'd1;
            end else if (inc && (count != DWELL_MAX)) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/s444_lamp_monitor.sv
// Tracks the two-approach signal phase from the sampled lamp vector and flags
// illegal encodings, illegal transitions and short dwells.
module s444_lamp_monitor
    import s444_mon_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MIN_ALLRED = 1
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       EN,
    input  logic [5:0] LAMP,
    input  logic       ERR_CLR,
    output logic [2:0] PHASE,
    output logic [7:0] DWELL,
    output logic       LOCKED,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] CYCLES
);

    localparam logic [7:0] MIN_G8 = 8'(MIN_GREEN);
    localparam logic [7:0] MIN_Y8 = 8'(MIN_YELLOW);
    localparam logic [7:0] MIN_A8 = 8'(MIN_ALLRED);

    phase_t    phase;
    err_code_t err_code;
    logic      err;
    logic      locked;
    logic      first_phase;
    logic [7:0] cycles;
    logic [7:0] dwell;

    enc_t      enc;
    phase_t    succ;
    phase_t    next_phase;
    err_code_t vcode;
    logic      violation;
    logic      lock;
    logic      advance;
    logic      hold;
    logic [7:0] min_dwell;

    always_comb begin
        case (phase)
            PH_AG, PH_BG: min_dwell = MIN_G8;
            PH_AY, PH_BY: min_dwell = MIN_Y8;
            default:      min_dwell = MIN_A8;
        endcase
    end

    // Checks are ordered so the highest-priority violation wins in a cycle.
    always_comb begin
        enc        = decode_lamp(LAMP);
        succ       = successor(phase, enc);
        next_phase = phase;
        vcode      = ERR_NONE;
        violation  = 1'b0;
        lock       = 1'b0;
        advance    = 1'b0;
        hold       = 1'b0;
        if (enc == ENC_ILLEGAL) begin
            violation = 1'b1;
            vcode     = ERR_ENCODING;
        end else if (phase == PH_UNLOCKED) begin
            if (enc == ENC_AG) begin
                lock       = 1'b1;
                next_phase = PH_AG;
            end else if (enc == ENC_BG) begin
                lock       = 1'b1;
                next_phase = PH_BG;
            end
        end else if (enc == phase_enc(phase)) begin
            hold = 1'b1;
        end else if (succ == PH_UNLOCKED) begin
            violation = 1'b1;
            vcode     = ERR_TRANSITION;
        end else if (!first_phase && (dwell < min_dwell)) begin
            violation = 1'b1;
            vcode     = ERR_SHORT;
        end else begin
            advance    = 1'b1;
            next_phase = succ;
        end
    end

    s444_dwell_ctr u_dwell (
        .clk   (CK),
        .rst   (RST),
        .en    (EN),
        .clear (violation),
        .load  (lock | advance),
        .inc   (hold),
        .count (dwell)
    );

    // first_phase marks a phase whose start was not observed, so its
    // dwell cannot be judged on exit.
    always_ff @(posedge CK) begin
        if (RST) begin
            phase       <= PH_UNLOCKED;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            cycles      <= 8'd0;
            first_phase <= 1'b0;
        end else if (EN) begin
            if (violation) begin
                phase       <= PH_UNLOCKED;
                locked      <= 1'b0;
                first_phase <= 1'b0;
                err         <= 1'b1;
                if (!err || ERR_CLR) begin
                    err_code <= vcode;
                end
            end else begin
                if (ERR_CLR) begin
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                end
                if (lock) begin
                    phase       <= next_phase;
                    locked      <= 1'b1;
                    first_phase <= 1'b1;
                end else if (advance) begin
                    phase       <= next_phase;
                    first_phase <= 1'b0;
                    if (phase == PH_RED_B) begin
                        cycles <= cycles + 8'd1;
                    end
                end
            end
        end
    end

    assign PHASE    = phase;
    assign DWELL    = dwell;
    assign LOCKED   = locked;
    assign ERR      = err;
    assign ERR_CODE = err_code;
    assign CYCLES   = cycles;

endmodule
